// File: rtl/axis_frame_writer_if.sv
// Stream-sink and AXI4 write-channel bundle for axis_frame_writer.
// master is the frame writer's side; slave is the stream source plus memory side.
interface axis_frame_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [ID_WIDTH-1:0]     m_axi_awid;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axis_frame_writer.sv
// Stream-to-memory frame writer: one INCR burst (<= BURST_LEN beats) in flight, awvalid 1 cycle after the FIFO fills;
// tready drops when the FIFO is full or after tlast. Define AXIS_FRAME_LEN_CHECK_EN to add the FRAME_WORDS length check.
module axis_frame_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int ID_WIDTH    = 8,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  axis_frame_writer_if.master   bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PW    = $clog2(BURST_LEN);
  localparam int CW    = PW + 1;
  localparam logic [CW-1:0]         FULL       = CW'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BYTES);

  if (BURST_LEN < 2 || BURST_LEN > 256 || (BURST_LEN & (BURST_LEN - 1)) != 0 || FRAME_WORDS < 1) begin : g_bad_params
    $error("axis_frame_writer: invalid BURST_LEN or FRAME_WORDS");
  end

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [BURST_LEN];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_last_seen, r_busy, r_done, r_err, r_awvalid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_beat;

  logic          w_push, w_pop, w_push_last, w_len_err, w_done_err, w_last_nxt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_push     = bus.s_axis_tvalid & bus.s_axis_tready;
  assign w_pop      = bus.m_axi_wvalid & bus.m_axi_wready;
  assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_last_nxt = r_last_seen | w_push_last;

`ifdef AXIS_FRAME_LEN_CHECK_EN
  logic [31:0] r_words;
  logic        w_hit;

  // The FRAME_WORDS-th word closes the frame even without tlast.
  assign w_hit       = (r_words + 32'd1) == 32'(FRAME_WORDS);
  assign w_push_last = w_push & (bus.s_axis_tlast | w_hit);
  assign w_len_err   = w_push & w_hit & ~bus.s_axis_tlast;
  assign w_done_err  = r_words != 32'(FRAME_WORDS);

  always_ff @(posedge clk) begin
    if (rst)                          r_words <= '0;
    else if (r_state == S_IDLE && start) r_words <= '0;
    else if (w_push)                  r_words <= r_words + 32'd1;
  end
`else
  assign w_push_last = w_push & bus.s_axis_tlast;
  assign w_len_err   = 1'b0;
  assign w_done_err  = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  assign bus.s_axis_tready = r_busy & (r_count != FULL) & ~r_last_seen;
  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awlen   = r_len;
  assign bus.m_axi_awsize  = 3'($clog2(BYTES));
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wvalid  = (r_state == S_DATA) && (r_count != '0);
  assign bus.m_axi_wdata   = bus.m_axi_wvalid ? r_mem[r_rptr] : '0;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = bus.m_axi_wvalid && (r_beat == r_len);
  assign bus.m_axi_bready  = (r_state == S_RESP);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_last_seen <= 1'b0;
      r_awvalid   <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_push_last) r_last_seen <= 1'b1;
      if (w_len_err)   r_err       <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          r_addr      <= base_addr;
          r_err       <= 1'b0;
          r_last_seen <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= S_FILL;
        end
        // Decide on next-cycle occupancy so a full FIFO raises awvalid one cycle after its last push.
        S_FILL: if (w_cnt_nxt == FULL || (w_last_nxt && w_cnt_nxt != '0)) begin
          r_len     <= 8'(w_cnt_nxt) - 8'd1;
          r_beat    <= '0;
          r_awvalid <= 1'b1;
          r_state   <= S_ADDR;
        end else if (w_last_nxt) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
          if (w_done_err) r_err <= 1'b1;
        end
        S_ADDR: if (bus.m_axi_awready) begin
          r_awvalid <= 1'b0;
          r_state   <= S_DATA;
        end
        S_DATA: if (w_pop) begin
          r_beat <= r_beat + 8'd1;
          if (r_beat == r_len) r_state <= S_RESP;
        end
        S_RESP: if (bus.m_axi_bvalid) begin
          if (bus.m_axi_bresp != 2'b00) r_err <= 1'b1;
          r_addr  <= r_addr + (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) * BEAT_BYTES;
          r_state <= S_FILL;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_frame_writer.sv
// Scoreboard bench for axis_frame_writer: expected AW/W traffic is queued at stimulus time and
// popped by a monitor on every handshake; a bench-side AXI slave stores beats into a memory model.
module tb_axis_frame_writer;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, err;
  logic [AW-1:0] base_addr;

  always #5 clk = ~clk;

  axis_frame_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axis_frame_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN(BL), .FRAME_WORDS(4096)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         aw_delay = 0;
  bit         wtoggle  = 1'b0;
  logic [1:0] bresp0   = 2'b00;

  bit            aw_open = 1'b0, b_pend = 1'b0, b_hs = 1'b0, saw_full = 1'b0;
  int            aw_cnt = 0, b_cnt = 0, mcnt = 0, last_b_cyc = 0, done_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] mem [16384];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] word(input int f, input int i);
    return {8'(f), 8'h5A, 16'(i)};
  endfunction

  // AXI slave: awready after aw_delay cycles of awvalid, optional toggling wready, one B per wlast.
  initial begin
    int aw_wait;
    aw_wait = 0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_axi_awvalid) begin
        bus.m_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        bus.m_axi_awready = 1'b0;
        aw_wait = 0;
      end
      bus.m_axi_wready = wtoggle ? ~bus.m_axi_wready : 1'b1;
      if (b_hs) begin
        bus.m_axi_bvalid = 1'b0;
        b_hs = 1'b0;
      end
      if (b_pend) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp  = (b_cnt == 0) ? bresp0 : 2'b00;
        b_pend = 1'b0;
      end
    end
  end

  // Monitor: samples on the falling edge what the next rising edge will commit.
  initial begin
    w_t e;
    forever begin
      @(negedge clk);
      if (mcnt == BL) begin
        saw_full = 1'b1;
        check("tready_when_full", 32'(bus.s_axis_tready), 0);
      end
      if (bus.m_axi_awvalid) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          check("awaddr", 32'(bus.m_axi_awaddr), 32'(exp_aw[0].addr));
          check("awlen", 32'(bus.m_axi_awlen), 32'(exp_aw[0].len));
          if (bus.m_axi_awready) begin
            void'(exp_aw.pop_front());
            wr_addr = bus.m_axi_awaddr;
            aw_open = 1'b1;
            aw_cnt++;
          end
        end
      end
      if (bus.m_axi_wvalid) begin
        check("w_before_aw", 32'(aw_open), 1);
        if (bus.m_axi_wready) begin
          if (exp_w.size() == 0) check("w_unexpected", 1, 0);
          else begin
            e = exp_w.pop_front();
            check("wdata", bus.m_axi_wdata, e.data);
            check("wlast", 32'(bus.m_axi_wlast), 32'(e.last));
          end
          mem[wr_addr[AW-1:2]] = bus.m_axi_wdata;
          wr_addr = wr_addr + AW'(4);
          mcnt--;
          if (bus.m_axi_wlast) begin
            aw_open = 1'b0;
            b_pend  = 1'b1;
          end
        end
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        b_hs = 1'b1;
        b_cnt++;
        last_b_cyc = cyc;
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) mcnt++;
      if (done) done_cnt++;
    end
  end

  task automatic push_expected(input int f, input logic [AW-1:0] base, input int n);
    aw_t a;
    w_t  w;
    for (int k = 0; k * BL < n; k++) begin
      int beats;
      beats  = (n - k * BL > BL) ? BL : n - k * BL;
      a.addr = base + AW'(k * BL * 4);
      a.len  = 8'(beats - 1);
      exp_aw.push_back(a);
      for (int j = 0; j < beats; j++) begin
        w.data = word(f, k * BL + j);
        w.last = (j == beats - 1);
        exp_w.push_back(w);
      end
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 1);
    check("err_cleared_on_start", 32'(err), 0);
    @(posedge clk); #1;
  endtask

  task automatic send_words(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      bit hs;
      int t;
      bus.s_axis_tdata  = word(f, i);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = (i == n - 1);
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 500) begin
        @(negedge clk);
        hs = bus.s_axis_tready;
        @(posedge clk); #1;
        t++;
      end
      if (!hs) check("tready_timeout", 0, 1);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic run_frame(input int f, input logic [AW-1:0] base, input int n, input int awd,
                           input bit wtog, input logic [1:0] br0, input bit exp_err, input bit exp_full);
    int ok;
    bit got_done;
    aw_delay = awd;
    wtoggle  = wtog;
    bresp0   = br0;
    b_cnt    = 0;
    aw_cnt   = 0;
    done_cnt = 0;
    saw_full = 1'b0;
    push_expected(f, base, n);
    pulse_start(base);
    send_words(f, n);
    got_done = 1'b0;
    for (int t = 0; t < 3000 && !got_done; t++) begin
      @(negedge clk);
      got_done = done;
    end
    check("done_seen", 32'(got_done), 1);
    check("err_at_done", 32'(err), 32'(exp_err));
    check("done_after_b", 32'(cyc > last_b_cyc), 1);
    @(negedge clk);
    @(negedge clk);
    check("done_pulse_count", 32'(done_cnt), 1);
    check("busy_after_done", 32'(busy), 0);
    check("err_sticky", 32'(err), 32'(exp_err));
    check("aw_bursts", 32'(aw_cnt), 32'((n + BL - 1) / BL));
    check("aw_queue_drained", 32'(exp_aw.size()), 0);
    check("w_queue_drained", 32'(exp_w.size()), 0);
    ok = 0;
    for (int i = 0; i < n; i++)
      if (mem[(int'(base) >> 2) + i] === word(f, i)) ok++;
    check("memory_words", 32'(ok), 32'(n));
    if (exp_full) check("tready_dropped_full", 32'(saw_full), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    bit hit;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_tready", 32'(bus.s_axis_tready), 0);
    check("rst_awvalid", 32'(bus.m_axi_awvalid), 0);
    check("rst_wvalid", 32'(bus.m_axi_wvalid), 0);
    check("rst_wlast", 32'(bus.m_axi_wlast), 0);
    check("rst_bready", 32'(bus.m_axi_bready), 0);
    check("rst_awaddr", 32'(bus.m_axi_awaddr), 0);
    check("rst_awid", 32'(bus.m_axi_awid), 0);
    check("rst_awsize", 32'(bus.m_axi_awsize), 2);
    check("rst_awburst", 32'(bus.m_axi_awburst), 1);
    check("rst_wstrb", 32'(bus.m_axi_wstrb), 32'hF);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(1, 16'h1000, 32, 0, 1'b0, 2'b00, 1'b0, 1'b0);
    run_frame(2, 16'h1000, 20, 0, 1'b0, 2'b00, 1'b0, 1'b0);
    run_frame(3, 16'h2000,  1, 0, 1'b0, 2'b00, 1'b0, 1'b0);
    run_frame(4, 16'h3000, 32, 5, 1'b1, 2'b00, 1'b0, 1'b1);
    run_frame(5, 16'h4000, 32, 0, 1'b0, 2'b10, 1'b1, 1'b0);
    run_frame(6, 16'h5000, 20, 0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Reset in the middle of the second burst's data phase.
    aw_delay = 0;
    wtoggle  = 1'b0;
    bresp0   = 2'b00;
    aw_cnt   = 0;
    b_cnt    = 0;
    push_expected(7, 16'h7000, 32);
    pulse_start(16'h7000);
    send_words(7, 32);
    hit = 1'b0;
    for (int t = 0; t < 500 && !hit; t++) begin
      @(negedge clk);
      hit = (aw_cnt == 2) && bus.m_axi_wvalid && bus.m_axi_wready;
    end
    check("reach_second_burst_data", 32'(hit), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_awvalid", 32'(bus.m_axi_awvalid), 0);
    check("midrst_wvalid", 32'(bus.m_axi_wvalid), 0);
    check("midrst_tready", 32'(bus.s_axis_tready), 0);
    check("midrst_err", 32'(err), 0);
    exp_aw.delete();
    exp_w.delete();
    aw_open = 1'b0;
    b_pend  = 1'b0;
    b_hs    = bus.m_axi_bvalid;
    mcnt    = 0;

    run_frame(8, 16'h6000, 20, 0, 1'b0, 2'b00, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_frame_writer.md
Name:
axis_frame_writer

Overview:
Downstream sink for the image-read pipeline. Consumes the 32-bit AXI-Stream pixel words produced by the rectify read path and writes them to memory through AXI4 INCR write bursts, starting at a programmable base address. Used to store rectified frames back into axi_ram and to close the read→process→write loop in simulation.

Parameters:
DATA_WIDTH, 32, AXI and AXIS data width; wstrb width is DATA_WIDTH/8.
ADDR_WIDTH, 16, AXI byte-address width.
ID_WIDTH, 8, awid width. awid is constant 0.
BURST_LEN, 16, maximum beats per burst and internal FIFO depth. Power of 2, range 2..256.
FRAME_WORDS, 4096, expected words per frame. Used only by the optional feature.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame. Ignored while busy.
base_addr  in  ADDR_WIDTH  frame start byte address, sampled on start. Must be aligned to BURST_LEN*DATA_WIDTH/8.
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the final B response
err  out  1  sticky error flag, cleared on start
s_axis_tdata  in  DATA_WIDTH  pixel word
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  marks the final word of the frame
m_axi_awid  out  ID_WIDTH  constant 0
m_axi_awaddr  out  ADDR_WIDTH  burst start address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  log2(DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_WIDTH  FIFO head word
m_axi_wstrb  out  DATA_WIDTH/8  all ones
m_axi_wlast  out  1  final beat of the burst
m_axi_wvalid  out  1  write valid
m_axi_wready  in  1  write ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset values: all outputs are 0 except the constants (awid=0, awsize, awburst=01, wstrb=all ones). FIFO is emptied, state goes to IDLE, err is cleared.
- Reset mid-burst abandons the transaction without completing the handshake.
- FIFO: depth BURST_LEN.
  - s_axis_tready = busy & !fifo_full & !last_seen.
  - A word is accepted when tvalid & tready.
  - last_seen is set when a word is accepted with tlast=1.
- State machine:
  - IDLE: on start, latch addr=base_addr, clear err, go to FILL.
  - FILL: when fifo_count==BURST_LEN, or last_seen with fifo_count>0, go to ADDR with len=fifo_count-1.
    - If last_seen and fifo_count==0, go to DONE.
  - ADDR: awvalid=1. Hold awaddr/awlen stable until awready. Then go to DATA.
  - DATA: wvalid=1 whenever FIFO is non-empty. Pop on wvalid & wready. wlast is asserted on beat len.
    - After the wlast handshake, go to RESP.
  - RESP: bready=1. On bvalid, set err if bresp!=0.
    - addr += (len+1)*DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH. Go to FILL.
  - DONE: pulse done for one cycle, drop busy, go to IDLE.
- Outstanding transactions: exactly one burst at a time. No W beat is driven before the AW handshake.
- Concurrent fill: the stream may keep filling the FIFO during DATA and RESP. Words accepted during DATA belong to the next burst only after the current burst's len beats have popped.
  - Simultaneous push and pop keeps fifo_count unchanged.
- Minimum latency: from the BURST_LEN-th accepted word to awvalid is 1 cycle.
- Partial final burst: when tlast arrives with fewer than BURST_LEN words pending, awlen=count-1. A 1-word frame gives awlen=0.
- Since base_addr is aligned and BURST_LEN*bytes ≤ 4096, no burst crosses a 4 KB boundary.

Optional Feature:
AXIS_FRAME_LEN_CHECK_EN
- Defined: an internal word counter (32-bit) counts accepted stream words.
  - On done, err is set if count != FRAME_WORDS.
  - If count reaches FRAME_WORDS without tlast, the block treats that word as last: last_seen=1, err set.
- Undefined: no counter; the frame ends only on tlast.

Test Plan:
- start with base_addr=0x1000, 32 words, last on word 32, ready always high → two AW with awaddr 0x1000 and 0x1040, awlen 15. Memory 0x1000..0x107C equals the data. done pulses once, err=0.
- 20-word frame → awlen 15 then awlen 3 at 0x1040, wlast on beats 16 and 4.
- Single-word frame → one AW with awlen=0. wlast is high on the only beat. done follows the B handshake.
- awready delayed 5 cycles and wready toggling every other cycle → awaddr/awlen are stable while awvalid is high, no W before AW, data order is preserved, tready drops when the FIFO holds 16 words.
- bresp=2'b10 on the first burst → err=1 stays set through done and clears on the next start.
- rst asserted during DATA of the 2nd burst → next cycle busy=0, awvalid=wvalid=0, tready=0. A new start writes a fresh frame correctly.
